// File: rtl/c5_fetch_buf_pkg.sv
// ---------------------------------------------------------------------------
// c5_fetch_buf_pkg
// Shared constants and types for the c5 instruction-fetch stage:
//   NOP            canonical RISC-V NOP (addi x0, x0, 0) shown to decode
//                  whenever no real instruction is available
//   C5_RESET_PC    default first fetch address after reset
//   depth_ok()     legal prefetch-queue depth check (power of two, 2..16)
//   fetch_entry_t  one prefetch-queue entry: {pc, instr}
// ---------------------------------------------------------------------------
package c5_fetch_buf_pkg;

    localparam logic [31:0] NOP         = 32'h0000_0013;
    localparam logic [31:0] C5_RESET_PC = 32'h0000_0000;
    localparam int          C5_DEPTH_MIN = 2;
    localparam int          C5_DEPTH_MAX = 16;

    // The queue pointers rely on natural binary wrap, so the depth must be
    // a power of two as well as lying inside the supported range.
    function automatic bit depth_ok(input int depth);
        return (depth >= C5_DEPTH_MIN) && (depth <= C5_DEPTH_MAX) &&
               ((depth & (depth - 1)) == 0);
    endfunction

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/c5_fetch_buf_fifo.sv
// ---------------------------------------------------------------------------
// c5_fifo_flush
// Synchronous circular FIFO with a single-cycle flush.
//   I_clk, I_rst   clock, synchronous active-high reset
//   I_push, I_data write one entry (ignored when full)
//   I_pop          drop the head entry (ignored when empty)
//   I_flush        empty the FIFO: count and both pointers return to 0
//   O_data         head entry (valid when !O_empty)
//   O_full/O_empty occupancy flags
//   O_count        number of stored entries, $clog2(DEPTH)+1 bits
// ---------------------------------------------------------------------------
module c5_fifo_flush #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     I_clk,
    input  logic                     I_rst,
    input  logic                     I_push,
    input  logic [WIDTH-1:0]         I_data,
    input  logic                     I_pop,
    input  logic                     I_flush,
    output logic [WIDTH-1:0]         O_data,
    output logic                     O_full,
    output logic                     O_empty,
    output logic [$clog2(DEPTH):0]   O_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign O_full  = (count == CW'(DEPTH));
    assign O_empty = (count == '0);
    assign O_count = count;
    assign O_data  = mem[rd_ptr];

    // Guard the requests so a misbehaving caller can never corrupt the count.
    assign do_push = I_push && !O_full;
    assign do_pop  = I_pop && !O_empty;

    // Storage array carries no reset; only the pointers define validity.
    always_ff @(posedge I_clk) begin
        if (do_push && !I_flush) begin
            mem[wr_ptr] <= I_data;
        end
    end

    // Pointers and occupancy. Flush has the same effect as reset.
    always_ff @(posedge I_clk) begin
        if (I_rst || I_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/c5_fetch_buf.sv
// ---------------------------------------------------------------------------
// c5_fetch_buf
// Instruction-fetch stage with prefetch queue for the c5 pipeline.
//   I_clk, I_rst          clock, synchronous active-high reset
//   O_adr, O_stb          fetch address / request to the instruction bus
//   I_instr, I_ack        zero-latency bus response
//   I_stall               decode cannot consume; output register holds
//   I_pc_src, I_pc_branch redirect request and its target
//   O_instr, O_pc,        instruction handed to decode, its PC, PC + 4,
//   O_pc_plus_4, O_valid  and whether it is a real fetched instruction
// Fetching runs ahead of decode until the queue is full. An empty queue lets
// an accepted beat bypass straight into the output register.
// ---------------------------------------------------------------------------
module c5_fetch_buf
    import c5_fetch_buf_pkg::*;
#(
    parameter logic [31:0] RESET_PC = C5_RESET_PC,
    parameter int          DEPTH    = 4
) (
    input  logic        I_clk,
    input  logic        I_rst,
    output logic [31:0] O_adr,
    output logic        O_stb,
    input  logic [31:0] I_instr,
    input  logic        I_ack,
    input  logic        I_stall,
    input  logic        I_pc_src,
    input  logic [31:0] I_pc_branch,
    output logic [31:0] O_instr,
    output logic [31:0] O_pc,
    output logic [31:0] O_pc_plus_4,
    output logic        O_valid
);

    localparam int CW = $clog2(DEPTH) + 1;

    if (!depth_ok(DEPTH)) begin : g_depth_check
        $error("c5_fetch_buf: DEPTH must be a power of two in 2..16");
    end

    logic [31:0]   fetch_pc;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc;
    logic          out_valid;

    fetch_entry_t  head;
    fetch_entry_t  beat;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    logic          accept;
    logic          advance;
    logic          bypass;
    logic          push;
    logic          pop;

    // Request is a function of the registered occupancy; reset masks it so
    // nothing is fetched while the stage is being initialised.
    assign O_stb  = !I_rst && (fifo_count != CW'(DEPTH));
    assign accept = O_stb && I_ack && !I_pc_src;

    // The output register may move only when decode is ready and no
    // redirect is pending. Queued words always drain ahead of a new beat.
    assign advance = !I_stall && !I_pc_src;
    assign pop     = advance && !fifo_empty;
    assign bypass  = advance && fifo_empty && accept;
    assign push    = accept && !bypass && !fifo_full;

    assign beat.pc    = fetch_pc;
    assign beat.instr = I_instr;

    c5_fifo_flush #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .I_clk   (I_clk),
        .I_rst   (I_rst),
        .I_push  (push),
        .I_data  (beat),
        .I_pop   (pop),
        .I_flush (I_pc_src),
        .O_data  (head),
        .O_full  (fifo_full),
        .O_empty (fifo_empty),
        .O_count (fifo_count)
    );

    // Fetch PC and decode-facing output register. Reset beats redirect,
    // redirect beats everything else, including a stall.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            fetch_pc  <= RESET_PC;
            out_instr <= NOP;
            out_pc    <= '0;
            out_valid <= 1'b0;
        end else if (I_pc_src) begin
            fetch_pc  <= I_pc_branch;
            out_instr <= NOP;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (!I_stall) begin
                if (!fifo_empty) begin
                    out_instr <= head.instr;
                    out_pc    <= head.pc;
                    out_valid <= 1'b1;
                end else if (accept) begin
                    out_instr <= I_instr;
                    out_pc    <= fetch_pc;
                    out_valid <= 1'b1;
                end else begin
                    out_instr <= NOP;
                    out_valid <= 1'b0;
                end
            end
        end
    end

    assign O_adr       = fetch_pc;
    assign O_instr     = out_instr;
    assign O_pc        = out_pc;
    assign O_pc_plus_4 = out_pc + 32'd4;
    assign O_valid     = out_valid;

endmodule

// File: tb/tb_c5_fetch_buf.sv
// ---------------------------------------------------------------------------
// tb_c5_fetch_buf
// Directed bench for c5_fetch_buf (RESET_PC = 0x100, DEPTH = 4). The bus
// model answers every address with a word derived from that address, so
// each delivered instruction can be tied back to the PC it was fetched from.
// ---------------------------------------------------------------------------
module tb_c5_fetch_buf;

    localparam logic [31:0] NOP_W  = 32'h0000_0013;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        I_clk;
    logic        I_rst;
    logic [31:0] O_adr;
    logic        O_stb;
    logic [31:0] I_instr;
    logic        I_ack;
    logic        I_stall;
    logic        I_pc_src;
    logic [31:0] I_pc_branch;
    logic [31:0] O_instr;
    logic [31:0] O_pc;
    logic [31:0] O_pc_plus_4;
    logic        O_valid;

    int vectors;
    int miscompares;

    c5_fetch_buf #(
        .RESET_PC (RST_PC),
        .DEPTH    (4)
    ) dut (
        .I_clk       (I_clk),
        .I_rst       (I_rst),
        .O_adr       (O_adr),
        .O_stb       (O_stb),
        .I_instr     (I_instr),
        .I_ack       (I_ack),
        .I_stall     (I_stall),
        .I_pc_src    (I_pc_src),
        .I_pc_branch (I_pc_branch),
        .O_instr     (O_instr),
        .O_pc        (O_pc),
        .O_pc_plus_4 (O_pc_plus_4),
        .O_valid     (O_valid)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    function automatic logic [31:0] bus_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0003;
    endfunction

    // Zero-latency bus: data for the presented address in the same cycle.
    always_comb I_instr = bus_word(O_adr);

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge I_clk);
        #1;
    endtask

    task automatic test_reset();
        I_rst = 1'b1; I_ack = 1'b1; I_stall = 1'b0; I_pc_src = 1'b0;
        I_pc_branch = '0;
        for (int i = 0; i < 3; i++) step();
        vectors++;
        if (O_stb !== 1'b0 || O_valid !== 1'b0 || O_adr !== RST_PC) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got stb=%b valid=%b adr=%h want stb=0 valid=0 adr=%h",
                     O_stb, O_valid, O_adr, RST_PC);
        end
        vectors++;
        if (O_instr !== NOP_W || O_pc !== 32'h0 || O_pc_plus_4 !== 32'h4) begin
            miscompares++;
            $display("[TB] FAIL reset_out: got instr=%h pc=%h pc4=%h want %h 0 4",
                     O_instr, O_pc, O_pc_plus_4, NOP_W);
        end
        I_rst = 1'b0;
        #1;
        vectors++;
        if (O_adr !== 32'h100 || O_stb !== 1'b1 || O_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL first_cycle: got adr=%h stb=%b valid=%b want 100 1 0",
                     O_adr, O_stb, O_valid);
        end
        step();
        vectors++;
        if (O_adr !== 32'h104 || O_valid !== 1'b1 || O_pc !== 32'h100 ||
            O_pc_plus_4 !== 32'h104 || O_instr !== bus_word(32'h100)) begin
            miscompares++;
            $display("[TB] FAIL first_valid: got adr=%h valid=%b pc=%h pc4=%h instr=%h want 104 1 100 104 %h",
                     O_adr, O_valid, O_pc, O_pc_plus_4, O_instr, bus_word(32'h100));
        end
        step();
        vectors++;
        if (O_adr !== 32'h108 || O_pc !== 32'h104) begin
            miscompares++;
            $display("[TB] FAIL second_fetch: got adr=%h pc=%h want 108 104", O_adr, O_pc);
        end
    endtask

    task automatic test_stall_fill();
        int pushes;
        pushes = 0;
        I_stall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (O_stb && I_ack) pushes++;
            step();
            vectors++;
            if (O_pc !== 32'h104 || O_valid !== 1'b1 || O_instr !== bus_word(32'h104)) begin
                miscompares++;
                $display("[TB] FAIL stall_hold[%0d]: got pc=%h valid=%b instr=%h want 104 1 %h",
                         i, O_pc, O_valid, O_instr, bus_word(32'h104));
            end
        end
        vectors++;
        if (pushes != 4 || O_stb !== 1'b0 || O_adr !== 32'h118) begin
            miscompares++;
            $display("[TB] FAIL stall_fill: got pushes=%0d stb=%b adr=%h want 4 0 118",
                     pushes, O_stb, O_adr);
        end
        I_stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            logic [31:0] exp_pc;
            exp_pc = 32'h108 + 32'(4 * i);
            step();
            vectors++;
            if (O_valid !== 1'b1 || O_pc !== exp_pc || O_instr !== bus_word(exp_pc)) begin
                miscompares++;
                $display("[TB] FAIL drain[%0d]: got valid=%b pc=%h instr=%h want 1 %h %h",
                         i, O_valid, O_pc, O_instr, exp_pc, bus_word(exp_pc));
            end
        end
        vectors++;
        if (O_adr !== 32'h128) begin
            miscompares++;
            $display("[TB] FAIL drain_adr: got %h want 128", O_adr);
        end
    endtask

    task automatic test_redirect_full();
        // Three entries are queued; one more stalled beat fills the queue.
        I_stall = 1'b1;
        step();
        vectors++;
        if (O_stb !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL full_stb: got %b want 0", O_stb);
        end
        I_pc_src = 1'b1; I_pc_branch = 32'h2000;
        step();
        vectors++;
        if (O_valid !== 1'b0 || O_instr !== NOP_W || O_adr !== 32'h2000 || O_stb !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL redirect_full: got valid=%b instr=%h adr=%h stb=%b want 0 %h 2000 1",
                     O_valid, O_instr, O_adr, O_stb, NOP_W);
        end
        I_pc_src = 1'b0; I_stall = 1'b0;
        step();
        vectors++;
        if (O_valid !== 1'b1 || O_pc !== 32'h2000 || O_instr !== bus_word(32'h2000)) begin
            miscompares++;
            $display("[TB] FAIL redirect_target: got valid=%b pc=%h instr=%h want 1 2000 %h",
                     O_valid, O_pc, O_instr, bus_word(32'h2000));
        end
        // Redirect while a beat for 0x2004 is being acked: it must vanish.
        I_pc_src = 1'b1; I_pc_branch = 32'h3000;
        step();
        vectors++;
        if (O_valid !== 1'b0 || O_adr !== 32'h3000) begin
            miscompares++;
            $display("[TB] FAIL redirect_ack: got valid=%b adr=%h want 0 3000", O_valid, O_adr);
        end
        I_pc_src = 1'b0;
        step();
        vectors++;
        if (O_valid !== 1'b1 || O_pc !== 32'h3000) begin
            miscompares++;
            $display("[TB] FAIL redirect_drop: got valid=%b pc=%h want 1 3000", O_valid, O_pc);
        end
    endtask

    task automatic test_wait_states();
        logic        ack_seq   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] exp_pc    [4] = '{32'h3004, 32'h3004, 32'h3004, 32'h3008};
        for (int i = 0; i < 4; i++) begin
            logic [31:0] exp_instr;
            I_ack = ack_seq[i];
            exp_instr = ack_seq[i] ? bus_word(exp_pc[i]) : NOP_W;
            step();
            vectors++;
            if (O_valid !== ack_seq[i] || O_pc !== exp_pc[i] || O_instr !== exp_instr) begin
                miscompares++;
                $display("[TB] FAIL wait_state[%0d]: got valid=%b pc=%h instr=%h want %b %h %h",
                         i, O_valid, O_pc, O_instr, ack_seq[i], exp_pc[i], exp_instr);
            end
        end
        I_ack = 1'b1;
    endtask

    task automatic test_wrap();
        I_pc_src = 1'b1; I_pc_branch = 32'hFFFF_FFF8;
        step();
        I_pc_src = 1'b0;
        step();
        step();
        vectors++;
        if (O_pc !== 32'hFFFF_FFFC || O_pc_plus_4 !== 32'h0 || O_adr !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL wrap_top: got pc=%h pc4=%h adr=%h want fffffffc 0 0",
                     O_pc, O_pc_plus_4, O_adr);
        end
        step();
        vectors++;
        if (O_pc !== 32'h0 || O_pc_plus_4 !== 32'h4 || O_valid !== 1'b1 ||
            O_instr !== bus_word(32'h0)) begin
            miscompares++;
            $display("[TB] FAIL wrap_zero: got pc=%h pc4=%h valid=%b instr=%h want 0 4 1 %h",
                     O_pc, O_pc_plus_4, O_valid, O_instr, bus_word(32'h0));
        end
    endtask

    task automatic test_reset_mid_drain();
        I_stall = 1'b1;
        for (int i = 0; i < 4; i++) step();
        I_stall = 1'b0;
        step();
        vectors++;
        if (O_pc !== 32'h4) begin
            miscompares++;
            $display("[TB] FAIL mid_drain_pc: got %h want 4", O_pc);
        end
        I_rst = 1'b1; I_pc_src = 1'b1; I_pc_branch = 32'h5000;
        step();
        vectors++;
        if (O_adr !== RST_PC || O_valid !== 1'b0 || O_instr !== NOP_W ||
            O_pc !== 32'h0 || O_pc_plus_4 !== 32'h4 || O_stb !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_drain: got adr=%h valid=%b instr=%h pc=%h pc4=%h stb=%b want 100 0 %h 0 4 0",
                     O_adr, O_valid, O_instr, O_pc, O_pc_plus_4, O_stb, NOP_W);
        end
        I_rst = 1'b0; I_pc_src = 1'b0; I_ack = 1'b0;
        step();
        vectors++;
        if (O_valid !== 1'b0 || O_stb !== 1'b1 || O_adr !== RST_PC) begin
            miscompares++;
            $display("[TB] FAIL reset_empty: got valid=%b stb=%b adr=%h want 0 1 100",
                     O_valid, O_stb, O_adr);
        end
        I_ack = 1'b1;
        step();
        vectors++;
        if (O_valid !== 1'b1 || O_pc !== RST_PC || O_instr !== bus_word(RST_PC)) begin
            miscompares++;
            $display("[TB] FAIL reset_restart: got valid=%b pc=%h instr=%h want 1 100 %h",
                     O_valid, O_pc, O_instr, bus_word(RST_PC));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_stall_fill();
        test_redirect_full();
        test_wait_states();
        test_wrap();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
